// File: rtl/uart_ctrl_pkg.sv
// rtl/uart_ctrl_pkg.sv - shared FSM encoding and 8N1 frame constants for uart_ctrl
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - power-of-two FIFO with show-ahead head output
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointer update; a push against a full FIFO is simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_ctrl.sv
// rtl/uart_ctrl.sv - 8N1 UART with TX FIFO, RX holding register and sticky error flags
module uart_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int TX_DEPTH     = 4
) (
    input  logic       i_clk,
    input  logic       reset,
    input  logic [7:0] databus,
    input  logic       IOload,
    input  logic       rx_rd,
    input  logic       rxd,
    output logic       txd,
    output logic [7:0] rx_data,
    output logic       tx_full,
    output logic       rx_avail,
    output logic       rx_overrun,
    output logic       rx_ferr
);

    localparam logic [7:0] BIT_RELOAD  = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] HALF_RELOAD = 8'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0] STOP_RELOAD = 8'(CLKS_PER_BIT * STOP_BITS - 1);
    localparam logic [2:0] LAST_BIT    = 3'(DATA_BITS - 1);

    uart_state_t tx_state, tx_state_nx;
    logic [7:0]  tx_cnt, tx_cnt_nx;
    logic [2:0]  tx_idx, tx_idx_nx;
    logic [7:0]  tx_shift, tx_shift_nx;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_head;

    uart_state_t rx_state, rx_state_nx;
    logic [7:0]  rx_cnt, rx_cnt_nx;
    logic [2:0]  rx_idx, rx_idx_nx;
    logic [7:0]  rx_shift, rx_shift_nx;
    logic        rx_meta, rx_sync, rx_prev;
    logic        rx_deliver, rx_frame_err;

    assign fifo_push = !IOload && !reset;
    assign tx_full   = fifo_full;

    uart_fifo #(
        .WIDTH(8),
        .DEPTH(TX_DEPTH)
    ) u_tx_fifo (
        .clk  (i_clk),
        .reset(reset),
        .push (fifo_push),
        .pop  (fifo_pop),
        .din  (databus),
        .full (fifo_full),
        .empty(fifo_empty),
        .head (fifo_head)
    );

    // TX state register; txd is registered from the current state, which adds the one-cycle launch delay.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_state_nx;
            tx_cnt   <= tx_cnt_nx;
            tx_idx   <= tx_idx_nx;
            tx_shift <= tx_shift_nx;
            case (tx_state)
                ST_START: txd <= 1'b0;
                ST_DATA:  txd <= tx_shift[0];
                default:  txd <= 1'b1;
            endcase
        end
    end

    // TX next state: STOP chains straight into START when more bytes are queued.
    always_comb begin
        tx_state_nx = tx_state;
        tx_cnt_nx   = tx_cnt;
        tx_idx_nx   = tx_idx;
        tx_shift_nx = tx_shift;
        fifo_pop    = 1'b0;
        case (tx_state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    tx_shift_nx = fifo_head;
                    tx_cnt_nx   = BIT_RELOAD;
                    tx_state_nx = ST_START;
                end
            end
            ST_START: begin
                if (tx_cnt == 8'd0) begin
                    tx_cnt_nx   = BIT_RELOAD;
                    tx_idx_nx   = 3'd0;
                    tx_state_nx = ST_DATA;
                end else begin
                    tx_cnt_nx = tx_cnt - 8'd1;
                end
            end
            ST_DATA: begin
                if (tx_cnt == 8'd0) begin
                    tx_shift_nx = {1'b0, tx_shift[7:1]};
                    if (tx_idx == LAST_BIT) begin
                        tx_cnt_nx   = STOP_RELOAD;
                        tx_state_nx = ST_STOP;
                    end else begin
                        tx_cnt_nx = BIT_RELOAD;
                        tx_idx_nx = tx_idx + 3'd1;
                    end
                end else begin
                    tx_cnt_nx = tx_cnt - 8'd1;
                end
            end
            ST_STOP: begin
                if (tx_cnt == 8'd0) begin
                    if (!fifo_empty) begin
                        fifo_pop    = 1'b1;
                        tx_shift_nx = fifo_head;
                        tx_cnt_nx   = BIT_RELOAD;
                        tx_state_nx = ST_START;
                    end else begin
                        tx_state_nx = ST_IDLE;
                    end
                end else begin
                    tx_cnt_nx = tx_cnt - 8'd1;
                end
            end
            default: tx_state_nx = ST_IDLE;
        endcase
    end

    // Two-flop synchronizer plus one delayed copy for falling-edge detection; all idle high.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // RX state register.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_nx;
            rx_cnt   <= rx_cnt_nx;
            rx_idx   <= rx_idx_nx;
            rx_shift <= rx_shift_nx;
        end
    end

    // RX next state: half-bit wait to centre on the start bit, then full-bit steps.
    always_comb begin
        rx_state_nx  = rx_state;
        rx_cnt_nx    = rx_cnt;
        rx_idx_nx    = rx_idx;
        rx_shift_nx  = rx_shift;
        rx_deliver   = 1'b0;
        rx_frame_err = 1'b0;
        case (rx_state)
            ST_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_cnt_nx   = HALF_RELOAD;
                    rx_state_nx = ST_START;
                end
            end
            ST_START: begin
                if (rx_cnt == 8'd0) begin
                    if (rx_sync) begin
                        rx_state_nx = ST_IDLE;
                    end else begin
                        rx_cnt_nx   = BIT_RELOAD;
                        rx_idx_nx   = 3'd0;
                        rx_state_nx = ST_DATA;
                    end
                end else begin
                    rx_cnt_nx = rx_cnt - 8'd1;
                end
            end
            ST_DATA: begin
                if (rx_cnt == 8'd0) begin
                    rx_shift_nx = {rx_sync, rx_shift[7:1]};
                    rx_cnt_nx   = BIT_RELOAD;
                    if (rx_idx == LAST_BIT) rx_state_nx = ST_STOP;
                    else                    rx_idx_nx   = rx_idx + 3'd1;
                end else begin
                    rx_cnt_nx = rx_cnt - 8'd1;
                end
            end
            ST_STOP: begin
                if (rx_cnt == 8'd0) begin
                    if (rx_sync) rx_deliver   = 1'b1;
                    else         rx_frame_err = 1'b1;
                    rx_state_nx = ST_IDLE;
                end else begin
                    rx_cnt_nx = rx_cnt - 8'd1;
                end
            end
            default: rx_state_nx = ST_IDLE;
        endcase
    end

    // Holding register: a delivery wins over a pop; overrun only when an unread byte is replaced.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            rx_data    <= 8'h00;
            rx_avail   <= 1'b0;
            rx_overrun <= 1'b0;
            rx_ferr    <= 1'b0;
        end else begin
            if (rx_deliver) begin
                rx_data  <= rx_shift;
                rx_avail <= 1'b1;
                if (rx_avail && !rx_rd) rx_overrun <= 1'b1;
            end else if (rx_rd) begin
                rx_avail <= 1'b0;
            end
            if (rx_frame_err) rx_ferr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_ctrl.sv
// tb/tb_uart_ctrl.sv - self-checking bench for uart_ctrl against a behavioural model
module tb_uart_ctrl;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int HALF  = CPB / 2;
    localparam int FRAME = 10 * CPB;

    logic       i_clk = 1'b0;
    logic       reset;
    logic       IOload;
    logic       rx_rd;
    logic       rxd;
    logic [7:0] databus;
    logic       txd;
    logic       tx_full;
    logic       rx_avail;
    logic       rx_overrun;
    logic       rx_ferr;
    logic [7:0] rx_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // model state
    logic [7:0] mq[$];
    int         m_rem   = 0;
    logic [7:0] m_byte  = 8'h00;
    logic       m_txd   = 1'b1;
    logic       m_avail = 1'b0;
    logic       m_ovr   = 1'b0;
    logic       m_ferr  = 1'b0;
    logic [7:0] m_data  = 8'h00;
    int         ev[int];
    bit         rx_line[$];

    uart_ctrl #(
        .CLKS_PER_BIT(CPB),
        .TX_DEPTH    (DEPTH)
    ) dut (
        .i_clk     (i_clk),
        .reset     (reset),
        .databus   (databus),
        .IOload    (IOload),
        .rx_rd     (rx_rd),
        .rxd       (rxd),
        .txd       (txd),
        .rx_data   (rx_data),
        .tx_full   (tx_full),
        .rx_avail  (rx_avail),
        .rx_overrun(rx_overrun),
        .rx_ferr   (rx_ferr)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // line level of an 8N1 frame at cycle offset pos from the start of the start bit
    function automatic logic frame_bit(input logic [7:0] b, input int pos);
        int k;
        k = pos / CPB;
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic model_update();
        bit pop_now;
        bit acc_now;
        cyc++;
        if (reset) begin
            mq.delete();
            m_rem   = 0;
            m_txd   = 1'b1;
            m_avail = 1'b0;
            m_ovr   = 1'b0;
            m_ferr  = 1'b0;
            m_data  = 8'h00;
            ev.delete();
            return;
        end
        m_txd   = (m_rem == 0) ? 1'b1 : frame_bit(m_byte, FRAME - m_rem);
        pop_now = (m_rem <= 1) && (mq.size() > 0);
        acc_now = !IOload && (mq.size() < DEPTH);
        if (pop_now) begin
            m_byte = mq.pop_front();
            m_rem  = FRAME;
        end else if (m_rem > 0) begin
            m_rem--;
        end
        if (acc_now) mq.push_back(databus);
        if (ev.exists(cyc)) begin
            if (ev[cyc] < 0) begin
                m_ferr = 1'b1;
            end else begin
                if (m_avail && !rx_rd) m_ovr = 1'b1;
                m_data  = 8'(ev[cyc]);
                m_avail = 1'b1;
            end
            ev.delete(cyc);
        end else if (rx_rd) begin
            m_avail = 1'b0;
        end
    endtask

    task automatic compare();
        chk("txd",        {31'd0, txd},        {31'd0, m_txd});
        chk("tx_full",    {31'd0, tx_full},    {31'd0, (mq.size() == DEPTH)});
        chk("rx_avail",   {31'd0, rx_avail},   {31'd0, m_avail});
        chk("rx_data",    {24'd0, rx_data},    {24'd0, m_data});
        chk("rx_overrun", {31'd0, rx_overrun}, {31'd0, m_ovr});
        chk("rx_ferr",    {31'd0, rx_ferr},    {31'd0, m_ferr});
    endtask

    task automatic tick();
        rxd = (rx_line.size() > 0) ? rx_line.pop_front() : 1'b1;
        @(posedge i_clk);
        model_update();
        @(negedge i_clk);
        compare();
    endtask

    task automatic run_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int gap, output int d);
        int n;
        n = cyc + 1 + rx_line.size();
        for (int k = 0; k < FRAME; k++) rx_line.push_back(frame_bit(b, k) & ((k < 9 * CPB) || stop_ok));
        for (int g = 0; g < gap; g++) rx_line.push_back(1'b1);
        d = n + 2 + HALF + 9 * CPB;
        ev[d] = stop_ok ? int'(b) : -1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (!(mq.size() == 0 && m_rem == 0 && rx_line.size() == 0 && ev.num() == 0) && guard < 4000) begin
            tick();
            guard++;
        end
        chk("drain_bound", {31'd0, (guard < 4000)}, 32'd1);
        repeat (8) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [9:0] f55;
        int         w;
        int         d1;
        int         d2;
        int         dd;
        bit         sok;

        reset   = 1'b1;
        IOload  = 1'b1;
        rx_rd   = 1'b0;
        rxd     = 1'b1;
        databus = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_txd",     {31'd0, txd},        32'd1);
        chk("rst_full",    {31'd0, tx_full},    32'd0);
        chk("rst_avail",   {31'd0, rx_avail},   32'd0);
        chk("rst_ovr",     {31'd0, rx_overrun}, 32'd0);
        chk("rst_ferr",    {31'd0, rx_ferr},    32'd0);
        chk("rst_data",    {24'd0, rx_data},    32'h00);

        // single byte 0x55: fall two cycles after the write, LSB first
        f55     = 10'b1010101010;
        IOload  = 1'b0;
        databus = 8'h55;
        tick();
        w      = cyc;
        IOload = 1'b1;
        tick();
        chk("tx55_latency", {31'd0, txd}, 32'd1);
        for (int i = 0; i < FRAME; i++) begin
            tick();
            chk("tx55_bit", {31'd0, txd}, {31'd0, f55[i / CPB]});
        end
        tick();
        chk("tx55_idle", {31'd0, txd}, 32'd1);

        // five back-to-back writes plus one dropped write
        for (int i = 0; i < 6; i++) begin
            IOload  = 1'b0;
            databus = 8'(8'h10 + i);
            tick();
            if (i == 0) w = cyc;
            if (i == 4) chk("full_after_5", {31'd0, tx_full}, 32'd1);
        end
        IOload = 1'b1;
        chk("full_after_6", {31'd0, tx_full}, 32'd1);
        run_until(w + 2 + FRAME);
        chk("b2b_no_gap", {31'd0, txd}, 32'd0);
        run_until(w + 2 + 5 * FRAME);
        chk("sixth_dropped", {31'd0, txd}, 32'd1);
        chk("fifo_drained", {31'd0, tx_full}, 32'd0);

        // receive 0xA3, then pop
        send_frame(8'hA3, 1'b1, CPB, d1);
        run_until(d1 - 1);
        chk("rxA3_before", {31'd0, rx_avail}, 32'd0);
        tick();
        chk("rxA3_avail", {31'd0, rx_avail}, 32'd1);
        chk("rxA3_data", {24'd0, rx_data}, 32'hA3);
        rx_rd = 1'b1;
        tick();
        rx_rd = 1'b0;
        chk("rxA3_popped", {31'd0, rx_avail}, 32'd0);
        chk("rxA3_hold", {24'd0, rx_data}, 32'hA3);
        drain();

        // overrun, then the same pair with a coincident read
        send_frame(8'h11, 1'b1, 0, d1);
        send_frame(8'h22, 1'b1, 0, d2);
        run_until(d2);
        chk("ovr_data", {24'd0, rx_data}, 32'h22);
        chk("ovr_flag", {31'd0, rx_overrun}, 32'd1);
        drain();
        do_reset();
        chk("rst2_ovr", {31'd0, rx_overrun}, 32'd0);
        chk("rst2_data", {24'd0, rx_data}, 32'h00);
        send_frame(8'h11, 1'b1, 0, d1);
        send_frame(8'h22, 1'b1, 0, d2);
        run_until(d2 - 1);
        rx_rd = 1'b1;
        tick();
        rx_rd = 1'b0;
        chk("coinc_no_ovr", {31'd0, rx_overrun}, 32'd0);
        chk("coinc_avail", {31'd0, rx_avail}, 32'd1);
        chk("coinc_data", {24'd0, rx_data}, 32'h22);
        drain();

        // randomized traffic on both directions
        for (int t = 0; t < 4000; t++) begin
            if ((t % 1000) < 500) IOload = ($urandom_range(0, 7) != 0);
            else                  IOload = ($urandom_range(0, 63) != 0);
            databus = 8'($urandom);
            rx_rd   = ($urandom_range(0, 7) == 0);
            if (rx_line.size() == 0) begin
                if ($urandom_range(0, 9) == 0) begin
                    rx_line.push_back(1'b0);
                    for (int g = 0; g < 2 * CPB; g++) rx_line.push_back(1'b1);
                end else begin
                    sok = ($urandom_range(0, 7) != 0);
                    send_frame(8'($urandom), sok,
                               sok ? int'($urandom_range(0, 2 * CPB)) : int'($urandom_range(1, 2 * CPB)), dd);
                end
            end
            tick();
        end
        IOload = 1'b1;
        rx_rd  = 1'b0;
        drain();
        do_reset();

        // glitch rejection, then a frame with a low stop bit
        rx_line.push_back(1'b0);
        for (int g = 0; g < 3 * CPB; g++) rx_line.push_back(1'b1);
        drain();
        chk("glitch_avail", {31'd0, rx_avail}, 32'd0);
        chk("glitch_ferr", {31'd0, rx_ferr}, 32'd0);
        send_frame(8'h5A, 1'b0, CPB, d1);
        run_until(d1);
        chk("ferr_flag", {31'd0, rx_ferr}, 32'd1);
        chk("ferr_no_avail", {31'd0, rx_avail}, 32'd0);
        drain();

        // reset in the middle of a TX data phase with bytes queued
        for (int i = 0; i < 3; i++) begin
            IOload  = 1'b0;
            databus = 8'(8'hC0 + i);
            tick();
            if (i == 0) w = cyc;
        end
        IOload = 1'b1;
        run_until(w + 20);
        reset   = 1'b1;
        IOload  = 1'b0;
        databus = 8'hAA;
        rx_rd   = 1'b1;
        tick();
        chk("midrst_txd", {31'd0, txd}, 32'd1);
        chk("midrst_full", {31'd0, tx_full}, 32'd0);
        reset  = 1'b0;
        IOload = 1'b1;
        rx_rd  = 1'b0;
        repeat (2 * FRAME) tick();
        chk("midrst_discarded", {31'd0, txd}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
